// File: rtl/maxpool2x2_fp.sv
// maxpool2x2_fp: streaming 2x2/stride-2 max pooling of IEEE-754 singles using a half-width line buffer
module maxpool2x2_fp #(
  parameter int DATAWIDTH = 32,
  parameter int IMG_W     = 24,
  parameter int IMG_H     = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = IMG_W > 2 ? $clog2(IMG_W / 2) : 1;
  localparam logic [DATAWIDTH-1:0] SIGN = {1'b1, {(DATAWIDTH-1){1'b0}}};
  logic [CW-1:0]        col_cnt;
  logic [RW-1:0]        row_cnt;
  logic [DATAWIDTH-1:0] hold;
  logic [DATAWIDTH-1:0] lbuf [2**AW];
  logic [AW-1:0]        idx;
  logic [DATAWIDTH-1:0] m, pool;
  logic                 col_last, row_last;
  // Sign-magnitude float mapped to an unsigned key whose integer order matches float order
  function automatic logic [DATAWIDTH-1:0] key(input logic [DATAWIDTH-1:0] x);
    return x[DATAWIDTH-1] ? ~x : (x | SIGN);
  endfunction
  // Later pixel replaces the earlier one only when strictly greater, so ties keep the earlier pixel
  always_comb begin
    idx      = AW'(col_cnt >> 1);
    col_last = col_cnt == CW'(IMG_W - 1);
    row_last = row_cnt == RW'(IMG_H - 1);
    m        = key(in_data) > key(hold) ? in_data : hold;
    pool     = key(m) > key(lbuf[idx]) ? m : lbuf[idx];
  end
  // Even rows park the horizontal pair maximum for the odd row below it
  always_ff @(posedge clk)
    if (in_valid && !clear && col_cnt[0] && !row_cnt[0]) lbuf[idx] <= m;
  // Raster counters, left-pixel hold register and registered pooled output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      hold       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= in_valid && col_cnt[0] && row_cnt[0];
      frame_done <= in_valid && col_last && row_last;
      if (in_valid) begin
        col_cnt <= col_last ? '0 : col_cnt + CW'(1);
        if (col_last) row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        if (!col_cnt[0]) hold <= in_data;
        if (col_cnt[0] && row_cnt[0]) out_data <= pool;
      end
    end
endmodule

// File: tb/tb_maxpool2x2_fp.sv
// tb_maxpool2x2_fp: table vectors, corner sequences and a 24x24 model check with a scoreboard queue
module tb_maxpool2x2_fp;
  logic        clk = 0, rst_n = 0, clear = 0, in_valid = 0;
  logic [31:0] in_data = 0;
  logic        ov0, ov1, ov2, fd0, fd1, fd2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  sel = 0;
  logic        ov, fd;
  logic [31:0] od;
  int          errors = 0, checks = 0, cyc = 0;
  typedef struct { logic [31:0] d; logic fd; int due; } exp_t;
  exp_t q[$];
  typedef struct { logic [31:0] p [4]; logic [31:0] e; } vec_t;
  vec_t vt [7];
  logic [31:0] t1 [8];
  logic [31:0] frame [24][24];

  maxpool2x2_fp #(.DATAWIDTH(32), .IMG_W(4), .IMG_H(2)) u_a (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .out_valid(ov0), .out_data(od0), .frame_done(fd0));
  maxpool2x2_fp #(.DATAWIDTH(32), .IMG_W(2), .IMG_H(2)) u_b (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .out_valid(ov1), .out_data(od1), .frame_done(fd1));
  maxpool2x2_fp #(.DATAWIDTH(32), .IMG_W(24), .IMG_H(24)) u_c (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .out_valid(ov2), .out_data(od2), .frame_done(fd2));

  assign ov = sel == 0 ? ov0 : sel == 1 ? ov1 : ov2;
  assign fd = sel == 0 ? fd0 : sel == 1 ? fd1 : fd2;
  assign od = sel == 0 ? od0 : sel == 1 ? od1 : od2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (ov || fd) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: out_valid=%0b frame_done=%0b data=%h cyc=%0d, required no output", ov, fd, od, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (!ov || od !== e.d || fd !== e.fd || cyc != e.due) begin
          errors++;
          $display("FAIL pooled_out: valid=%0b data=%h fd=%0b cyc=%0d, required valid=1 data=%h fd=%0b cyc=%0d",
                   ov, od, fd, cyc, e.d, e.fd, e.due);
        end
      end
    end

  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return fkey(b) > fkey(a) ? b : a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 in_valid = 0; clear = 0;
    end
  endtask

  task automatic beat(input logic [31:0] d, input bit has_exp, input logic [31:0] e, input bit efd, input int gap);
    exp_t x;
    idle(gap);
    @(posedge clk);
    #1 in_valid = 1; clear = 0; in_data = d;
    if (has_exp) begin
      x.d = e; x.fd = efd; x.due = cyc + 1;
      q.push_back(x);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 0; in_valid = 0; clear = 0;
    q.delete();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic drain(input string name);
    idle(4);
    check(name, 32'(q.size()), 32'd0);
  endtask

  task automatic send_t1(input int maxgap);
    for (int i = 0; i < 8; i++)
      beat(t1[i], i == 5 || i == 7, i == 5 ? 32'h3F00_0000 : 32'h3F80_0000, i == 7,
           maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  function automatic logic [31:0] rnd_tanh();
    logic [7:0] ex;
    if ($urandom_range(0, 15) == 0) return $urandom_range(0, 1) ? 32'h8000_0000 : 32'h0;
    ex = 8'($urandom_range(100, 126));
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  initial begin
    t1 = '{32'h3F000000, 32'hBF000000, 32'h3E4CCCCD, 32'h3F800000,
           32'hBF000000, 32'h3E4CCCCD, 32'h3E800000, 32'hBF800000};
    vt[0] = '{'{32'hBF000000, 32'hBE4CCCCD, 32'hBF400000, 32'hBF800000}, 32'hBE4CCCCD};
    vt[1] = '{'{32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000}, 32'h00000000};
    vt[2] = '{'{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000}, 32'h3F000000};
    vt[3] = '{'{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h3F800001}, 32'h3F800001};
    vt[4] = '{'{32'h7F800000, 32'h7FC00000, 32'h3F800000, 32'h00000000}, 32'h7FC00000};
    vt[5] = '{'{32'hFFC00000, 32'hFF800000, 32'hFFC00000, 32'hFFC00000}, 32'hFF800000};
    vt[6] = '{'{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000}, 32'h80000000};
    #23;
    check("reset_ov_a", 32'(ov0), 0); check("reset_od_a", od0, 0); check("reset_fd_a", 32'(fd0), 0);
    check("reset_od_b", od1, 0); check("reset_od_c", od2, 0);
    #1 rst_n = 1;
    sel = 0;
    send_t1(0);
    drain("t1_basic_drained");
    check("t1_out_hold", od0, 32'h3F800000);
    check("t1_ov_low", 32'(ov0), 0);
    send_t1(5);
    drain("t4_gapped_drained");
    send_t1(0);
    send_t1(0);
    drain("t5_b2b_drained");
    for (int i = 0; i < 5; i++) beat(t1[i], 0, 0, 0, 0);
    do_reset();
    send_t1(0);
    drain("t6_reset_drained");
    for (int i = 0; i < 5; i++) beat(t1[i], 0, 0, 0, 0);
    @(posedge clk);
    #1 clear = 1; in_valid = 1; in_data = 32'h7F000000;
    send_t1(0);
    drain("t6_clear_drained");
    sel = 1;
    do_reset();
    foreach (vt[v]) for (int i = 0; i < 4; i++) beat(vt[v].p[i], i == 3, vt[v].e, 1, 0);
    drain("table_drained");
    sel = 2;
    do_reset();
    for (int r = 0; r < 24; r++) for (int c = 0; c < 24; c++) frame[r][c] = rnd_tanh();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++) begin
        logic [31:0] e;
        e = fmax(fmax(fmax(frame[r-1 < 0 ? 0 : r-1][c-1 < 0 ? 0 : c-1], frame[r-1 < 0 ? 0 : r-1][c]),
                      frame[r][c-1 < 0 ? 0 : c-1]), frame[r][c]);
        beat(frame[r][c], r[0] && c[0], e, r == 23 && c == 23, $urandom_range(0, 7) == 0 ? 2 : 0);
      end
    drain("model_24x24_drained");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
